operand_fetch_stage: RTL and testbench

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/operand_fetch_stage.sv | 135 +++++++++++++
 tb/tb_operand_fetch_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: decodes register indices, reads operands with writeback bypass,
// detects load-use hazards and registers the instruction into the execute stage.
module operand_fetch_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_valid_i,
    input  logic [15:0] if_instr_i,
    input  logic [15:0] if_pc_i,
    output logic        id_ready_o,
    output logic [3:0]  rf_src1_o,
    output logic [3:0]  rf_src2_o,
    input  logic [15:0] rf_data1_i,
    input  logic [15:0] rf_data2_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_reg_i,
    input  logic [15:0] wb_data_i,
    input  logic        ex_stall_i,
    input  logic        flush_i,
    output logic        ex_valid_o,
    output logic [3:0]  ex_opcode_o,
    output logic [3:0]  ex_rd_o,
    output logic [3:0]  ex_rs1_o,
    output logic [3:0]  ex_rs2_o,
    output logic [15:0] ex_pc_o,
    output logic [15:0] ex_op1_o,
    output logic [15:0] ex_op2_o,
    output logic [15:0] bubble_cnt_o
);

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_LLB = 4'b1010;
    localparam logic [3:0] OP_LHB = 4'b1011;

    logic        ex_valid_q,  ex_valid_d;
    logic [3:0]  ex_opcode_q, ex_opcode_d;
    logic [3:0]  ex_rd_q,     ex_rd_d;
    logic [3:0]  ex_rs1_q,    ex_rs1_d;
    logic [3:0]  ex_rs2_q,    ex_rs2_d;
    logic [15:0] ex_pc_q,     ex_pc_d;
    logic [15:0] ex_op1_q,    ex_op1_d;
    logic [15:0] ex_op2_q,    ex_op2_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    logic [3:0]  opcode;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        hazard;

    assign opcode = if_instr_i[15:12];

    // LLB/LHB read their own destination; SW reads the data register from the rd field
    assign src1 = ((opcode == OP_LLB) || (opcode == OP_LHB)) ? if_instr_i[11:8] : if_instr_i[7:4];
    assign src2 = (opcode == OP_SW) ? if_instr_i[11:8] : if_instr_i[3:0];

    assign op1 = (src1 == 4'd0) ? 16'h0000 :
                 (wb_we_i && (wb_reg_i == src1)) ? wb_data_i : rf_data1_i;
    assign op2 = (src2 == 4'd0) ? 16'h0000 :
                 (wb_we_i && (wb_reg_i == src2)) ? wb_data_i : rf_data2_i;

    assign hazard = ex_valid_q && (ex_opcode_q == OP_LW) && (ex_rd_q != 4'd0) && if_valid_i &&
                    ((ex_rd_q == src1) || (ex_rd_q == src2));

    assign id_ready_o = !ex_stall_i && !hazard;
    assign rf_src1_o  = src1;
    assign rf_src2_o  = src2;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_opcode_d  = ex_opcode_q;
        ex_rd_d      = ex_rd_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_pc_d      = ex_pc_q;
        ex_op1_d     = ex_op1_q;
        ex_op2_d     = ex_op2_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (ex_stall_i) begin
            // held operands must not go stale while a writeback lands on their source
            if (wb_we_i && (ex_rs1_q != 4'd0) && (wb_reg_i == ex_rs1_q)) ex_op1_d = wb_data_i;
            if (wb_we_i && (ex_rs2_q != 4'd0) && (wb_reg_i == ex_rs2_q)) ex_op2_d = wb_data_i;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
            if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
        end else begin
            ex_valid_d  = if_valid_i;
            ex_opcode_d = opcode;
            ex_rd_d     = if_instr_i[11:8];
            ex_rs1_d    = src1;
            ex_rs2_d    = src2;
            ex_pc_d     = if_pc_i;
            ex_op1_d    = op1;
            ex_op2_d    = op2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q   <= 1'b0;
            ex_opcode_q  <= 4'd0;
            ex_rd_q      <= 4'd0;
            ex_rs1_q     <= 4'd0;
            ex_rs2_q     <= 4'd0;
            ex_pc_q      <= 16'h0000;
            ex_op1_q     <= 16'h0000;
            ex_op2_q     <= 16'h0000;
            bubble_cnt_q <= 16'h0000;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_rd_q      <= ex_rd_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_pc_q      <= ex_pc_d;
            ex_op1_q     <= ex_op1_d;
            ex_op2_q     <= ex_op2_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_opcode_o  = ex_opcode_q;
    assign ex_rd_o      = ex_rd_q;
    assign ex_rs1_o     = ex_rs1_q;
    assign ex_rs2_o     = ex_rs2_q;
    assign ex_pc_o      = ex_pc_q;
    assign ex_op1_o     = ex_op1_q;
    assign ex_op2_o     = ex_op2_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural register file model
// written from the writeback port.
module tb_operand_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_valid_i;
    logic [15:0] if_instr_i;
    logic [15:0] if_pc_i;
    logic        id_ready_o;
    logic [3:0]  rf_src1_o;
    logic [3:0]  rf_src2_o;
    logic [15:0] rf_data1_i;
    logic [15:0] rf_data2_i;
    logic        wb_we_i;
    logic [3:0]  wb_reg_i;
    logic [15:0] wb_data_i;
    logic        ex_stall_i;
    logic        flush_i;
    logic        ex_valid_o;
    logic [3:0]  ex_opcode_o;
    logic [3:0]  ex_rd_o;
    logic [3:0]  ex_rs1_o;
    logic [3:0]  ex_rs2_o;
    logic [15:0] ex_pc_o;
    logic [15:0] ex_op1_o;
    logic [15:0] ex_op2_o;
    logic [15:0] bubble_cnt_o;

    logic [15:0] rf [16];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    operand_fetch_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
        .id_ready_o(id_ready_o),
        .rf_src1_o(rf_src1_o), .rf_src2_o(rf_src2_o),
        .rf_data1_i(rf_data1_i), .rf_data2_i(rf_data2_i),
        .wb_we_i(wb_we_i), .wb_reg_i(wb_reg_i), .wb_data_i(wb_data_i),
        .ex_stall_i(ex_stall_i), .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_opcode_o(ex_opcode_o), .ex_rd_o(ex_rd_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_pc_o(ex_pc_o),
        .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .bubble_cnt_o(bubble_cnt_o)
    );

    // register file: R0 is deliberately writable so the stage must force index 0 to zero
    assign rf_data1_i = rf[rf_src1_o];
    assign rf_data2_i = rf[rf_src2_o];
    always @(posedge clk_i) if (wb_we_i) rf[wb_reg_i] <= wb_data_i;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
        rf[2] = 16'h0005; rf[3] = 16'h0007; rf[4] = 16'h0044; rf[5] = 16'h0055;
        rst_i = 1'b1; if_valid_i = 1'b0; if_instr_i = 16'h0000; if_pc_i = 16'h0000;
        wb_we_i = 1'b0; wb_reg_i = 4'd0; wb_data_i = 16'h0000;
        ex_stall_i = 1'b0; flush_i = 1'b0;
        step(); step();
        chk("rst_valid", 16'(ex_valid_o), 16'd0);
        chk("rst_bubble", bubble_cnt_o, 16'h0000);
        chk("rst_op1", ex_op1_o, 16'h0000);
        rst_i = 1'b0;

        // plain ADD R1, R2, R3
        if_valid_i = 1'b1; if_instr_i = 16'h1123; if_pc_i = 16'h0010;
        #1;
        chk("add_ready", 16'(id_ready_o), 16'd1);
        chk("add_src1", 16'(rf_src1_o), 16'd2);
        chk("add_src2", 16'(rf_src2_o), 16'd3);
        step();
        chk("add_valid", 16'(ex_valid_o), 16'd1);
        chk("add_op1", ex_op1_o, 16'h0005);
        chk("add_op2", ex_op2_o, 16'h0007);
        chk("add_rd", 16'(ex_rd_o), 16'd1);
        chk("add_opc", 16'(ex_opcode_o), 16'd1);
        chk("add_pc", ex_pc_o, 16'h0010);

        // same ADD with writeback bypass on R2
        wb_we_i = 1'b1; wb_reg_i = 4'd2; wb_data_i = 16'hBEEF; if_pc_i = 16'h0012;
        step();
        chk("byp_op1", ex_op1_o, 16'hBEEF);
        chk("byp_op2", ex_op2_o, 16'h0007);

        // writeback to R0 with a source of R0 must still read zero
        if_instr_i = 16'h1020; wb_reg_i = 4'd0; wb_data_i = 16'h5555; if_pc_i = 16'h0014;
        step();
        wb_we_i = 1'b0;
        chk("zero_op2", ex_op2_o, 16'h0000);
        chk("zero_op1_rf", ex_op1_o, 16'hBEEF);

        // operand index selection for LLB and SW
        if_instr_i = 16'hA3F0; #1;
        chk("llb_src1", 16'(rf_src1_o), 16'd3);
        chk("llb_src2", 16'(rf_src2_o), 16'd0);
        if_instr_i = 16'h9567; #1;
        chk("sw_src1", 16'(rf_src1_o), 16'd6);
        chk("sw_src2", 16'(rf_src2_o), 16'd5);

        // load-use: LW R4 then ADD R5, R4, R3
        if_instr_i = 16'h8412; if_pc_i = 16'h0020;
        step();
        chk("lw_opc", 16'(ex_opcode_o), 16'd8);
        if_instr_i = 16'h1543; if_pc_i = 16'h0022; #1;
        chk("lu_ready", 16'(id_ready_o), 16'd0);
        step();
        chk("lu_valid", 16'(ex_valid_o), 16'd0);
        chk("lu_bubble", bubble_cnt_o, 16'h0001);
        chk("lu_ready2", 16'(id_ready_o), 16'd1);
        step();
        chk("lu_add_valid", 16'(ex_valid_o), 16'd1);
        chk("lu_add_rd", 16'(ex_rd_o), 16'd5);
        chk("lu_add_op1", ex_op1_o, 16'h0044);
        chk("lu_add_op2", ex_op2_o, 16'h0007);
        chk("lu_bubble2", bubble_cnt_o, 16'h0001);

        // stall three cycles while R5 is written back underneath the held instruction
        if_instr_i = 16'h1650; if_pc_i = 16'h0030;
        step();
        chk("st_op1_pre", ex_op1_o, 16'h0055);
        chk("st_rs1", 16'(ex_rs1_o), 16'd5);
        if_instr_i = 16'h1700; if_pc_i = 16'h0032; ex_stall_i = 1'b1; #1;
        chk("st_ready", 16'(id_ready_o), 16'd0);
        step();
        chk("st_hold_op1", ex_op1_o, 16'h0055);
        wb_we_i = 1'b1; wb_reg_i = 4'd5; wb_data_i = 16'h1234;
        step();
        wb_we_i = 1'b0;
        step();
        chk("st_op1_wb", ex_op1_o, 16'h1234);
        chk("st_hold_rd", 16'(ex_rd_o), 16'd6);
        chk("st_hold_pc", ex_pc_o, 16'h0030);
        ex_stall_i = 1'b0;
        step();
        chk("st_rel_rd", 16'(ex_rd_o), 16'd7);
        chk("st_rel_pc", ex_pc_o, 16'h0032);
        if_valid_i = 1'b0;
        step();
        chk("st_once", 16'(ex_valid_o), 16'd0);

        // flush wins over stall
        if_valid_i = 1'b1; if_instr_i = 16'h1123; if_pc_i = 16'h0040;
        step();
        chk("fl_pre", 16'(ex_valid_o), 16'd1);
        flush_i = 1'b1; ex_stall_i = 1'b1;
        step();
        chk("fl_valid", 16'(ex_valid_o), 16'd0);
        flush_i = 1'b0; ex_stall_i = 1'b0;

        // reset coinciding with a load-use bubble
        if_instr_i = 16'h8412; if_pc_i = 16'h0050;
        step();
        if_instr_i = 16'h1543; if_pc_i = 16'h0052; #1;
        chk("rb_ready", 16'(id_ready_o), 16'd0);
        rst_i = 1'b1;
        step();
        chk("rb_valid", 16'(ex_valid_o), 16'd0);
        chk("rb_bubble", bubble_cnt_o, 16'h0000);
        chk("rb_op1", ex_op1_o, 16'h0000);
        chk("rb_pc", ex_pc_o, 16'h0000);
        chk("rb_opc", 16'(ex_opcode_o), 16'd0);
        rst_i = 1'b0; #1;
        chk("rb_ready_post", 16'(id_ready_o), 16'd1);
        step();
        chk("rb_post_valid", 16'(ex_valid_o), 16'd1);
        chk("rb_post_op1", ex_op1_o, 16'h0044);
        chk("rb_post_pc", ex_pc_o, 16'h0052);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
